// File: rtl/gpio_serial_loader_pkg.sv
// Shared definitions for the GPIO pad-configuration chain loader.
// Holds the loader state encoding, load strobe length, default chain geometry and the
// pad control word bit offsets that gpio_control_block also uses.
package gpio_serial_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD_SETUP,
    ST_LOAD,
    ST_DONE
  } loader_state_t;

  // Number of serial_clock cycles chain_load is held high.
  localparam int unsigned LOAD_STROBE_CYCLES = 2;

  localparam int unsigned NUM_GPIO_DEFAULT      = 38;
  localparam int unsigned PAD_CTRL_BITS_DEFAULT = 13;

  // Bit offsets inside one pad control word.
  localparam int unsigned PAD_MGMT_EN_BIT     = 0;
  localparam int unsigned PAD_OUT_DIS_BIT     = 1;
  localparam int unsigned PAD_HOLD_OVR_BIT    = 2;
  localparam int unsigned PAD_INP_DIS_BIT     = 3;
  localparam int unsigned PAD_IB_MODE_SEL_BIT = 4;
  localparam int unsigned PAD_ANALOG_EN_BIT   = 5;
  localparam int unsigned PAD_ANALOG_SEL_BIT  = 6;
  localparam int unsigned PAD_ANALOG_POL_BIT  = 7;
  localparam int unsigned PAD_SLOW_SEL_BIT    = 8;
  localparam int unsigned PAD_TRIP_SEL_BIT    = 9;
  localparam int unsigned PAD_DM_LSB          = 10;
  localparam int unsigned PAD_DM_WIDTH        = 3;

  // Word a control block reverts to while chain_resetn is low.
  localparam logic [PAD_CTRL_BITS_DEFAULT-1:0] GPIO_DEFAULTS = 13'h0403;

endpackage

// File: rtl/gpio_serial_shifter.sv
// Data path of the chain loader: a parallel-load PISO that serialises the pad image
// MSB first, and a SIPO that collects the bits returned from the chain tail.
// Ports:
//   serial_clock, resetn : clock / async active-low reset
//   load, load_data      : parallel load of the outgoing image
//   shift_en             : advance the outgoing image by one bit
//   capture_en           : shift serial_in into the readback LSB
//   serial_in            : chain tail data
//   tx_bit               : current outgoing bit (image MSB)
//   rx_data              : collected readback image
module gpio_serial_shifter
  import gpio_serial_loader_pkg::*;
#(
  parameter int unsigned WIDTH = NUM_GPIO_DEFAULT * PAD_CTRL_BITS_DEFAULT
) (
  input  logic             serial_clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             capture_en,
  input  logic             serial_in,
  output logic             tx_bit,
  output logic [WIDTH-1:0] rx_data
);

  logic [WIDTH-1:0] tx_shift;

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      tx_shift <= '0;
    end else if (load) begin
      tx_shift <= load_data;
    end else if (shift_en) begin
      tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      rx_data <= '0;
    end else if (capture_en) begin
      rx_data <= {rx_data[WIDTH-2:0], serial_in};
    end
  end

  assign tx_bit = tx_shift[WIDTH-1];

endmodule

// File: rtl/gpio_serial_loader.sv
// Transmit end of the GPIO pad-configuration shift chain. Serialises cfg_data into the
// chain (GPIO 0 at the head), strobes chain_load, and captures the previous chain image
// from chain_return into rb_data.
// Ports:
//   serial_clock, resetn : clock / async active-low reset
//   xfer_start           : 1-cycle request, cfg_data sampled when accepted
//   cfg_data             : flattened pad words, GPIO k at [k*B +: B]
//   xfer_busy, xfer_done : transfer in progress / 1-cycle completion pulse
//   rb_data              : chain image shifted out during the last transfer
//   chain_resetn         : resetn passed through to the chain
//   chain_clock, chain_data, chain_load : registered chain drive
//   chain_return         : serial output of the last block
module gpio_serial_loader
  import gpio_serial_loader_pkg::*;
#(
  parameter int unsigned NUM_GPIO      = NUM_GPIO_DEFAULT,
  parameter int unsigned PAD_CTRL_BITS = PAD_CTRL_BITS_DEFAULT
) (
  input  logic                              serial_clock,
  input  logic                              resetn,
  input  logic                              xfer_start,
  input  logic [NUM_GPIO*PAD_CTRL_BITS-1:0] cfg_data,
  output logic                              xfer_busy,
  output logic                              xfer_done,
  output logic [NUM_GPIO*PAD_CTRL_BITS-1:0] rb_data,
  output logic                              chain_resetn,
  output logic                              chain_clock,
  output logic                              chain_data,
  output logic                              chain_load,
  input  logic                              chain_return
);

  localparam int unsigned CHAIN_BITS = NUM_GPIO * PAD_CTRL_BITS;
  localparam int unsigned CNT_W      = (CHAIN_BITS > 1) ? $clog2(CHAIN_BITS) : 1;
  localparam int unsigned LCNT_W     = (LOAD_STROBE_CYCLES > 1) ? $clog2(LOAD_STROBE_CYCLES) : 1;

  loader_state_t     state, state_next;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [LCNT_W-1:0] load_cnt, load_cnt_next;
  logic              phase, phase_next;
  logic              clock_next, data_next, load_next, done_next;
  logic              sh_load, sh_shift, rb_capture, rb_update;
  logic              tx_bit;
  logic [CHAIN_BITS-1:0] rx_data;

  assign chain_resetn = resetn;

  gpio_serial_shifter #(
    .WIDTH(CHAIN_BITS)
  ) u_shifter (
    .serial_clock(serial_clock),
    .resetn      (resetn),
    .load        (sh_load),
    .load_data   (cfg_data),
    .shift_en    (sh_shift),
    .capture_en  (rb_capture),
    .serial_in   (chain_return),
    .tx_bit      (tx_bit),
    .rx_data     (rx_data)
  );

  // Chain outputs are registered from the current state, so they trail the state by
  // one cycle; xfer_busy is registered from the next state so it drops exactly when
  // xfer_done rises.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    load_cnt_next = load_cnt;
    phase_next    = phase;
    clock_next    = 1'b0;
    data_next     = chain_data;
    load_next     = 1'b0;
    done_next     = 1'b0;
    sh_load       = 1'b0;
    sh_shift      = 1'b0;
    rb_capture    = 1'b0;
    rb_update     = 1'b0;
    case (state)
      ST_IDLE: begin
        // A start during the xfer_done pulse belongs to the finished transfer.
        if (xfer_start && !xfer_done) begin
          sh_load      = 1'b1;
          bit_cnt_next = CNT_W'(CHAIN_BITS - 1);
          phase_next   = 1'b0;
          state_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_next = tx_bit;
        if (!phase) begin
          phase_next = 1'b1;
        end else begin
          // Rising chain_clock: tail output is still the previous fall's value.
          clock_next = 1'b1;
          rb_capture = 1'b1;
          phase_next = 1'b0;
          if (bit_cnt != '0) begin
            bit_cnt_next = bit_cnt - CNT_W'(1);
            sh_shift     = 1'b1;
          end else begin
            state_next = ST_LOAD_SETUP;
          end
        end
      end
      ST_LOAD_SETUP: begin
        load_cnt_next = '0;
        state_next    = ST_LOAD;
      end
      ST_LOAD: begin
        load_next = 1'b1;
        if (load_cnt == LCNT_W'(LOAD_STROBE_CYCLES - 1)) begin
          state_next = ST_DONE;
        end else begin
          load_cnt_next = load_cnt + LCNT_W'(1);
        end
      end
      ST_DONE: begin
        done_next  = 1'b1;
        rb_update  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      load_cnt    <= '0;
      phase       <= 1'b0;
      xfer_busy   <= 1'b0;
      xfer_done   <= 1'b0;
      chain_clock <= 1'b0;
      chain_data  <= 1'b0;
      chain_load  <= 1'b0;
      rb_data     <= '0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      load_cnt    <= load_cnt_next;
      phase       <= phase_next;
      xfer_busy   <= (state_next != ST_IDLE);
      xfer_done   <= done_next;
      chain_clock <= clock_next;
      chain_data  <= data_next;
      chain_load  <= load_next;
      if (rb_update) begin
        rb_data <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Self-checking bench for gpio_serial_loader. A 38-block chain of gpio_control_block
// models hangs off the main instance; a single-block chain hangs off a 1-GPIO instance.
// A timeline model (cycle index since the accepted start) gives the expected outputs,
// checked on every falling edge; directed tests add literal expectations.
module tb_gpio_serial_loader;
  import gpio_serial_loader_pkg::*;

  localparam int N      = 38;
  localparam int B      = 13;
  localparam int NB     = N * B;
  localparam int DONE_C = 2 * NB + 5;

  logic          serial_clock = 1'b0;
  logic          resetn       = 1'b1;
  logic          xfer_start   = 1'b0;
  logic [NB-1:0] cfg_data     = '0;
  logic          xfer_busy, xfer_done, chain_resetn, chain_clock, chain_data, chain_load, chain_return;
  logic [NB-1:0] rb_data;

  logic          s_start = 1'b0;
  logic [B-1:0]  s_cfg   = '0;
  logic          s_busy, s_done, s_cresetn, s_clk, s_data, s_load, s_ret;
  logic [B-1:0]  s_rb;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done_seen = 0;

  always #5 serial_clock = ~serial_clock;

  gpio_serial_loader #(.NUM_GPIO(N), .PAD_CTRL_BITS(B)) dut (
    .serial_clock(serial_clock), .resetn(resetn), .xfer_start(xfer_start), .cfg_data(cfg_data),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done), .rb_data(rb_data), .chain_resetn(chain_resetn),
    .chain_clock(chain_clock), .chain_data(chain_data), .chain_load(chain_load),
    .chain_return(chain_return)
  );

  gpio_serial_loader #(.NUM_GPIO(1), .PAD_CTRL_BITS(B)) dut_small (
    .serial_clock(serial_clock), .resetn(resetn), .xfer_start(s_start), .cfg_data(s_cfg),
    .xfer_busy(s_busy), .xfer_done(s_done), .rb_data(s_rb), .chain_resetn(s_cresetn),
    .chain_clock(s_clk), .chain_data(s_data), .chain_load(s_load), .chain_return(s_ret)
  );

  // Control block models: shift on clock rise, drive output on fall, latch on load rise.
  logic [B-1:0]  blk_sr   [N];
  logic          blk_out  [N];
  logic [B-1:0]  blk_word [N];
  logic [NB-1:0] blk_flat;

  always @(posedge chain_clock or negedge chain_resetn) begin
    if (!chain_resetn) begin
      for (int k = 0; k < N; k++) blk_sr[k] <= '0;
    end else begin
      blk_sr[0] <= {blk_sr[0][B-2:0], chain_data};
      for (int k = 1; k < N; k++) blk_sr[k] <= {blk_sr[k][B-2:0], blk_out[k-1]};
    end
  end
  always @(negedge chain_clock or negedge chain_resetn) begin
    if (!chain_resetn) for (int k = 0; k < N; k++) blk_out[k] <= 1'b0;
    else               for (int k = 0; k < N; k++) blk_out[k] <= blk_sr[k][B-1];
  end
  always @(posedge chain_load or negedge chain_resetn) begin
    if (!chain_resetn) for (int k = 0; k < N; k++) blk_word[k] <= GPIO_DEFAULTS;
    else               for (int k = 0; k < N; k++) blk_word[k] <= blk_sr[k];
  end
  assign chain_return = blk_out[N-1];
  always_comb begin
    blk_flat = '0;
    for (int k = 0; k < N; k++) blk_flat[k*B +: B] = blk_word[k];
  end

  logic [B-1:0] s_sr, s_word;
  logic         s_out;
  always @(posedge s_clk or negedge s_cresetn)
    if (!s_cresetn) s_sr <= '0; else s_sr <= {s_sr[B-2:0], s_data};
  always @(negedge s_clk or negedge s_cresetn)
    if (!s_cresetn) s_out <= 1'b0; else s_out <= s_sr[B-1];
  always @(posedge s_load or negedge s_cresetn)
    if (!s_cresetn) s_word <= GPIO_DEFAULTS; else s_word <= s_sr;
  assign s_ret = s_out;

  task automatic check_vec(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: m_c is the cycle index since the start request (request cycle = 0).
  logic          m_active = 1'b0;
  int            m_c      = 0;
  logic [NB-1:0] m_img    = '0;
  logic [NB-1:0] m_chain  = '0;
  logic [NB-1:0] rb_exp   = '0;

  always @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      m_active <= 1'b0;
      m_c      <= 0;
      m_chain  <= '0;
      rb_exp   <= '0;
    end else if (m_active) begin
      if (m_c == DONE_C) m_active <= 1'b0;
      else               m_c <= m_c + 1;
      if (m_c == DONE_C - 1) begin
        rb_exp  <= m_chain;
        m_chain <= m_img;
      end
    end else if (xfer_start) begin
      m_active <= 1'b1;
      m_c      <= 1;
      m_img    <= cfg_data;
    end
  end

  logic prev_clk  = 1'b0;
  logic prev_data = 1'b0;

  always @(negedge serial_clock) begin
    if (resetn) begin
      check_bit("xfer_busy", xfer_busy, m_active && (m_c <= DONE_C - 1));
      check_bit("xfer_done", xfer_done, m_active && (m_c == DONE_C));
      check_bit("chain_clock", chain_clock,
                m_active && (m_c >= 3) && (m_c <= 2 * NB + 1) && (m_c % 2 == 1));
      check_bit("chain_load", chain_load,
                m_active && ((m_c == 2 * NB + 3) || (m_c == 2 * NB + 4)));
      check_bit("chain_resetn", chain_resetn, 1'b1);
      check_vec("rb_data", rb_data, rb_exp);
      if (m_active && (m_c >= 3) && (m_c <= 2 * NB + 1) && (m_c % 2 == 1))
        check_bit("chain_data", chain_data, m_img[NB - 1 - (m_c - 3) / 2]);
      if (chain_load) check_bit("load_while_clock", chain_clock, 1'b0);
      if (chain_clock && !prev_clk) check_bit("data_stable_on_rise", chain_data, prev_data);
      if (xfer_done) n_done_seen <= n_done_seen + 1;
    end
    prev_clk  <= chain_clock;
    prev_data <= chain_data;
  end

  task automatic run_xfer(input logic [NB-1:0] img, input int p1, input int p2,
                          output int done_at, output int busy_cnt);
    @(posedge serial_clock); #1;
    cfg_data   = img;
    xfer_start = 1'b1;
    @(posedge serial_clock); #1;
    xfer_start = 1'b0;
    done_at  = -1;
    busy_cnt = 0;
    for (int c = 1; c < 3000; c++) begin
      xfer_start = (c == p1) || (c == p2);
      if (c == 20) cfg_data = ~img;
      if (xfer_busy) busy_cnt++;
      if (xfer_done) begin
        done_at = c;
        break;
      end
      @(posedge serial_clock); #1;
    end
    xfer_start = 1'b0;
  endtask

  logic [NB-1:0] img_a, img_b, img_def;
  int done_at, busy_cnt, done_before, busy_after, clk_pulses;

  initial begin
    for (int k = 0; k < N; k++) begin
      img_a[k*B +: B]   = B'((k * 257) & 'h1FFF);
      img_def[k*B +: B] = GPIO_DEFAULTS;
    end
    img_b = ~img_a;

    #2 resetn = 1'b0;
    repeat (3) @(posedge serial_clock);
    #1;
    check_bit("rst_busy", xfer_busy, 1'b0);
    check_bit("rst_done", xfer_done, 1'b0);
    check_bit("rst_chain_clock", chain_clock, 1'b0);
    check_bit("rst_chain_data", chain_data, 1'b0);
    check_bit("rst_chain_load", chain_load, 1'b0);
    check_vec("rst_rb_data", rb_data, '0);
    #2 resetn = 1'b1;

    // Test 1: image A
    run_xfer(img_a, -1, -1, done_at, busy_cnt);
    check_int("t1_done_cycle", done_at, 993);
    check_int("t1_busy_cycles", busy_cnt, 992);
    check_vec("t1_rb_zero", rb_data, '0);
    @(posedge chain_clock or posedge serial_clock); #1;
    check_vec("t1_block_words", blk_flat, img_a);
    check_int("t1_word1", int'(blk_word[1]), 'h0101);
    check_int("t1_word37", int'(blk_word[37]), 'h0525);

    // Tests 2+3: image B with ignored starts; readback must be A
    repeat (3) @(posedge serial_clock);
    done_before = n_done_seen;
    run_xfer(img_b, 10, 500, done_at, busy_cnt);
    check_int("t2_done_cycle", done_at, 993);
    check_int("t3_busy_cycles", busy_cnt, 992);
    check_vec("t2_rb_is_a", rb_data, img_a);
    xfer_start = 1'b1;
    @(posedge serial_clock); #1;
    xfer_start = 1'b0;
    busy_after = 0;
    repeat (6) begin
      if (xfer_busy) busy_after++;
      @(posedge serial_clock); #1;
    end
    check_int("t3_start_in_done_ignored", busy_after, 0);
    check_int("t3_single_done", n_done_seen - done_before, 1);
    check_vec("t2_block_words", blk_flat, img_b);

    // Test 4: reset during SHIFT
    done_before = n_done_seen;
    @(posedge serial_clock); #1;
    cfg_data = img_a;
    xfer_start = 1'b1;
    @(posedge serial_clock); #1;
    xfer_start = 1'b0;
    repeat (399) @(posedge serial_clock);
    #3 resetn = 1'b0;
    #1;
    check_bit("t4_busy", xfer_busy, 1'b0);
    check_bit("t4_clock", chain_clock, 1'b0);
    check_bit("t4_data", chain_data, 1'b0);
    check_bit("t4_load", chain_load, 1'b0);
    check_bit("t4_chain_resetn", chain_resetn, 1'b0);
    check_vec("t4_rb", rb_data, '0);
    check_vec("t4_block_defaults", blk_flat, img_def);
    repeat (3) @(posedge serial_clock);
    #3 resetn = 1'b1;
    repeat (700) @(posedge serial_clock);
    #1;
    check_int("t4_no_done", n_done_seen - done_before, 0);
    check_vec("t4_defaults_kept", blk_flat, img_def);

    // After reset the chain shift registers are clear again
    run_xfer(img_b, -1, -1, done_at, busy_cnt);
    check_int("t4b_done_cycle", done_at, 993);
    check_vec("t4b_rb_zero", rb_data, '0);

    // Test 5: single-block chain
    @(posedge serial_clock); #1;
    s_cfg   = 13'h1A5B;
    s_start = 1'b1;
    @(posedge serial_clock); #1;
    s_start = 1'b0;
    done_at = -1;
    clk_pulses = 0;
    for (int c = 1; c < 200; c++) begin
      if (s_clk) clk_pulses++;
      if (s_done) begin
        done_at = c;
        break;
      end
      @(posedge serial_clock); #1;
    end
    check_int("t5_done_cycle", done_at, 31);
    check_int("t5_clock_pulses", clk_pulses, 13);
    check_int("t5_block_word", int'(s_word), 'h1A5B);
    check_int("t5_rb_zero", int'(s_rb), 0);

    repeat (3) @(posedge serial_clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
